row_token_arbiter: RTL
======================

ROW_TOKEN_ARBITER -- requirements
Module: row_token_arbiter

Interface
REQ-001 Parameter ROWS, default 16, meaning number of row token inputs (legal range 2..256, power of two not required).
REQ-002 Parameter RR_MODE, default 0, meaning 0 = fixed priority (lowest index first), 1 = round-robin priority.
REQ-003 Derived localparam ADDR_W = clog2(ROWS), and CNT_W = clog2(ROWS+1); neither is user-overridable.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Token  input  ROWS  per-row hit request, level, sampled only when a scan is started.
REQ-007 Start  input  1  single-cycle pulse requesting a snapshot-and-scan.
REQ-008 RowReady  input  1  downstream accepts the presented row address.
REQ-009 RowValid  output  1  a row address is presented.
REQ-010 RowAddr  output  ADDR_W  binary index of the presented row.
REQ-011 Busy  output  1  high in states SCAN and DONE.
REQ-012 Done  output  1  one-cycle pulse ending a scan.
REQ-013 HitCount  output  CNT_W  rows transferred in the current or most recent scan.

Function
REQ-014 State machine with states IDLE, SCAN, DONE; only these three are reachable.
REQ-015 IDLE: Start=1 -> Pending register loads Token, HitCount clears to 0, next state SCAN.
REQ-016 Start is ignored in SCAN and DONE; it neither reloads Pending nor clears HitCount.
REQ-017 Token changes outside the Start-accept cycle have no effect on the ongoing scan.
REQ-018 SCAN: RowValid = (Pending != 0), combinational from the Pending register and priority pointer.
REQ-019 Fixed mode: RowAddr = lowest set index of Pending (index 0 highest priority).
REQ-020 Round-robin mode: RowAddr = lowest set index >= Pointer; if none, lowest set index overall (wrap).
REQ-021 Transfer = RowValid & RowReady; on transfer, the Pending bit at RowAddr clears and HitCount increments by 1.
REQ-022 Round-robin mode: on transfer, Pointer <= RowAddr+1, wrapping ROWS-1 -> 0; Pointer persists across scans and is unused in fixed mode.
REQ-023 RowAddr and RowValid are stable while RowValid=1 and RowReady=0 (no retraction, no address change).
REQ-024 Throughput: one transfer per cycle when RowReady is held high; the next row is presented in the cycle after a transfer.
REQ-025 SCAN with Pending == 0 (checked on the registered value) -> next state DONE; a scan of k rows with RowReady held high lasts k+1 SCAN cycles.
REQ-026 DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 RowValid=0 and RowAddr=0 in IDLE and DONE; RowAddr=0 whenever RowValid=0.
REQ-028 Start with Token all-zero: SCAN 1 cycle, DONE 1 cycle, HitCount=0, no RowValid.
REQ-029 HitCount holds its final value from DONE until the next accepted Start; max value ROWS, no overflow.

Reset
REQ-030 Reset asserted -> immediately: state IDLE, Pending=0, Pointer=0, HitCount=0, RowValid=0, RowAddr=0, Busy=0, Done=0.
REQ-031 Reset mid-scan aborts the scan with no Done pulse; remaining pending rows are discarded.
REQ-032 First Start after Reset deasserts is accepted on the first rising edge with Reset low.

Verification
REQ-033 ROWS=16, RR_MODE=0, Token=0x8421, Start, RowReady=1 -> RowAddr 0,5,10,15 on consecutive cycles, then Done; HitCount=4.
REQ-034 ROWS=16, RowReady=0 for 5 cycles after first RowValid -> RowAddr held at first row, RowValid held high, HitCount unchanged.
REQ-035 ROWS=12, RR_MODE=1, scan1 Token=0x004 (1 transfer, Pointer=3), scan2 Token=0x809 -> order 3,11,0.
REQ-036 Token=0 with Start -> Busy high 2 cycles, single Done pulse, RowValid never high, HitCount=0.
REQ-037 Token=0xFFFF, Reset asserted after 3 transfers -> all outputs 0 same cycle, no Done; next Start with Token=0x0002 -> single RowAddr=1.
REQ-038 Start pulsed during SCAN with different Token -> ignored; original row sequence and HitCount unaffected.

Source files
------------

// File: rtl/row_token_arbiter.sv
// Row token arbiter: snapshots a row-hit vector on Start, then hands out one
// row index per accepted handshake (fixed or round-robin order) until empty.
module row_token_arbiter #(
  parameter int ROWS    = 16,
  parameter int RR_MODE = 0,
  localparam int ADDR_W = $clog2(ROWS),
  localparam int CNT_W  = $clog2(ROWS + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ROWS-1:0]   Token,
  input  logic              Start,
  input  logic              RowReady,
  output logic              RowValid,
  output logic [ADDR_W-1:0] RowAddr,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  HitCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ROWS-1:0]   pending_q, pending_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

  logic              first_any;
  logic [ADDR_W-1:0] first_idx;
  logic              upper_any;
  logic [ADDR_W-1:0] upper_idx;
  logic [ADDR_W-1:0] sel_idx;
  logic [ROWS-1:0]   sel_mask;
  logic              row_valid;
  logic              transfer;

  // Descending walk so the last hit written is the lowest index; the "upper"
  // search only admits rows at or beyond the round-robin pointer.
  always_comb begin
    first_any = 1'b0;
    first_idx = '0;
    upper_any = 1'b0;
    upper_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        first_any = 1'b1;
        first_idx = ADDR_W'(i);
        if ((RR_MODE == 0) || (ADDR_W'(i) >= ptr_q)) begin
          upper_any = 1'b1;
          upper_idx = ADDR_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_idx   = upper_any ? upper_idx : first_idx;
    sel_mask  = ROWS'(1) << sel_idx;
    row_valid = (state_q == ST_SCAN) && first_any;
    transfer  = row_valid && RowReady;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pending_d = Token;
          hit_cnt_d = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!first_any) begin
          state_d = ST_DONE;
        end else if (transfer) begin
          pending_d = pending_q & ~sel_mask;
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
          if (RR_MODE != 0) begin
            ptr_d = (sel_idx == ADDR_W'(ROWS - 1)) ? '0 : sel_idx + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin
    RowValid = row_valid;
    RowAddr  = row_valid ? sel_idx : '0;
    Busy     = (state_q == ST_SCAN) || (state_q == ST_DONE);
    Done     = (state_q == ST_DONE);
    HitCount = hit_cnt_q;
  end

endmodule
